hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/sat_counter.sv | 33 +++
 rtl/hazard_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: forwarding-select encodings, stage valid bundle
// and the architectural zero register.
package cpu_pkg;

    localparam int ZERO_REG_DEFAULT = 31;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic ifid;
        logic idex;
        logic exmem;
        logic memwb;
    } stage_valid_t;

    // The younger producer (EX/MEM) holds the newer value, so it wins over MEM/WB.
    function automatic fwd_sel_e fwd_pick(input logic mem_hit, input logic wb_hit);
        if (mem_hit) return FWD_MEM;
        if (wb_hit)  return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc=1 and sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // NOTE: defaulting count_d before the conditional keeps this block free of latches.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: EX operand forwarding, load-use / stall-only interlocks,
// branch flush, stage valid bits and saturating performance counters.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int AW       = 5,
    parameter int ZERO_REG = ZERO_REG_DEFAULT,
    parameter int FWD_EN   = 1,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    id_rn,
    input  logic [AW-1:0]    id_rm,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic [AW-1:0]    ex_rn,
    input  logic [AW-1:0]    ex_rm,
    input  logic [AW-1:0]    ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [AW-1:0]    mem_rd,
    input  logic             mem_regwrite,
    input  logic             mem_br_taken,
    input  logic [AW-1:0]    wb_rd,
    input  logic             wb_regwrite,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             v_ifid,
    output logic             v_idex,
    output logic             v_exmem,
    output logic             v_memwb,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

    stage_valid_t valid_q;
    stage_valid_t valid_d;

    fwd_sel_e fwd_a_sel;
    fwd_sel_e fwd_b_sel;
    logic     mem_ok;
    logic     wb_ok;
    logic     ex_ld_ok;
    logic     ex_wr_ok;
    logic     id_hits_ex;
    logic     id_hits_mem;
    logic     stall;
    logic     flush;

    always_comb begin
        mem_ok    = valid_q.exmem & mem_regwrite & (mem_rd != ZR);
        wb_ok     = valid_q.memwb & wb_regwrite & (wb_rd != ZR);
        fwd_a_sel = FWD_RF;
        fwd_b_sel = FWD_RF;
        if (FWD_EN != 0) begin
            fwd_a_sel = fwd_pick(mem_ok && (mem_rd == ex_rn), wb_ok && (wb_rd == ex_rn));
            fwd_b_sel = fwd_pick(mem_ok && (mem_rd == ex_rm), wb_ok && (wb_rd == ex_rm));
        end
    end

    // Without forwarding, WB producers still need no stall: the register file writes through.
    always_comb begin
        ex_ld_ok    = valid_q.idex & ex_memread & (ex_rd != ZR);
        ex_wr_ok    = valid_q.idex & ex_regwrite & (ex_rd != ZR);
        id_hits_ex  = (id_use_rn & (ex_rd == id_rn)) | (id_use_rm & (ex_rd == id_rm));
        id_hits_mem = (id_use_rn & (mem_rd == id_rn)) | (id_use_rm & (mem_rd == id_rm));
        if (FWD_EN != 0) begin
            stall = ex_ld_ok & id_hits_ex;
        end else begin
            stall = (ex_wr_ok & id_hits_ex) | (mem_ok & id_hits_mem);
        end
        flush = valid_q.exmem & mem_br_taken;
    end

    // A taken branch squashes the younger stages; the branch itself moves on to WB.
    always_comb begin
        valid_d.ifid  = flush ? 1'b0 : (stall ? valid_q.ifid : 1'b1);
        valid_d.idex  = (flush | stall) ? 1'b0 : valid_q.ifid;
        valid_d.exmem = flush ? 1'b0 : valid_q.idex;
        valid_d.memwb = valid_q.exmem;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign fwd_a   = fwd_a_sel;
    assign fwd_b   = fwd_b_sel;
    assign pc_en   = ~stall | flush;
    assign ifid_en = ~stall | flush;
    assign v_ifid  = valid_q.ifid;
    assign v_idex  = valid_q.idex;
    assign v_exmem = valid_q.exmem;
    assign v_memwb = valid_q.memwb;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall & ~flush),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush),
        .count (flush_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_retire_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (valid_q.memwb),
        .count (retire_cnt)
    );

endmodule
